// File: rtl/bj_redirect_ctrl.sv
// rtl/bj_redirect_ctrl.sv - branch/jump/exception redirect sequencer between ID and instruction fetch
module bj_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter int          CNT_W    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        id_valid,
    input  logic        id_allowout,
    input  logic        bj_taken,
    input  logic [31:0] bj_target,
    input  logic        ds_fetched,
    input  logic        exc_redirect,
    input  logic [31:0] exc_target,
    input  logic        if_req_valid,
    input  logic        if_req_ready,
    input  logic        if_resp_valid,
    output logic        fetch_redirect,
    output logic [31:0] fetch_target,
    output logic        if_discard,
    output logic        if_req_block,
    output logic        ctrl_busy
);

    typedef enum logic [1:0] {BOOT, IDLE, WAIT_DS, PEND} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic [31:0]       tgt;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  drop_cnt;

    logic              req_fire;
    logic              accepted;
    logic              bj_fire;
    logic              drop_nz;
    logic              ds_resp;
    logic [CNT_W-1:0]  resp_dec;
    logic [CNT_W-1:0]  drop_on_accept;

    assign req_fire       = if_req_valid & if_req_ready;
    assign accepted       = fetch_redirect & req_fire;
    assign bj_fire        = id_valid & id_allowout & bj_taken;
    assign drop_nz        = (drop_cnt != '0);
    assign ds_resp        = if_resp_valid & ~drop_nz;
    assign resp_dec       = if_resp_valid ? CNT_ONE : '0;
    // Everything still in flight after this cycle's response is wrong-path; the redirect itself is not.
    assign drop_on_accept = inflight - resp_dec;

    assign fetch_redirect = (state == BOOT) | (state == PEND) | exc_redirect;
    assign fetch_target   = exc_redirect ? exc_target : tgt;
    assign if_discard     = if_resp_valid & ((state == PEND) | drop_nz | exc_redirect);
    assign if_req_block   = (inflight == CNT_MAX);
    assign ctrl_busy      = (state != IDLE) | drop_nz;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inflight <= '0;
        end else begin
            case ({req_fire, if_resp_valid})
                2'b10:   inflight <= inflight + CNT_ONE;
                2'b01:   inflight <= inflight - CNT_ONE;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_cnt <= '0;
        end else if (accepted && (exc_redirect || state == PEND)) begin
            drop_cnt <= drop_on_accept;
        end else if (if_resp_valid && drop_nz && state != PEND) begin
            drop_cnt <= drop_cnt - CNT_ONE;
        end
    end

    // Exceptions preempt any branch bookkeeping regardless of state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= BOOT;
            tgt   <= RESET_PC;
        end else if (exc_redirect) begin
            if (accepted) begin
                state <= IDLE;
            end else begin
                tgt   <= exc_target;
                state <= PEND;
            end
        end else begin
            case (state)
                BOOT: begin
                    if (accepted) state <= IDLE;
                end
                IDLE: begin
                    if (bj_fire) begin
                        tgt   <= bj_target;
                        state <= (ds_fetched || ds_resp) ? PEND : WAIT_DS;
                    end
                end
                WAIT_DS: begin
                    if (ds_resp) state <= PEND;
                end
                PEND: begin
                    if (accepted) state <= IDLE;
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_bj_redirect_ctrl.sv
// tb/tb_bj_redirect_ctrl.sv - randomized self-checking bench for bj_redirect_ctrl
module tb_bj_redirect_ctrl;

    localparam logic [31:0] RESET_PC = 32'hBFC00000;

    logic        clk;
    logic        resetn;
    logic        id_valid;
    logic        id_allowout;
    logic        bj_taken;
    logic [31:0] bj_target;
    logic        ds_fetched;
    logic        exc_redirect;
    logic [31:0] exc_target;
    logic        if_req_valid;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic        fetch_redirect;
    logic [31:0] fetch_target;
    logic        if_discard;
    logic        if_req_block;
    logic        ctrl_busy;

    int checks = 0;
    int errors = 0;

    bj_redirect_ctrl #(.RESET_PC(RESET_PC), .CNT_W(2)) dut (
        .clk(clk),
        .resetn(resetn),
        .id_valid(id_valid),
        .id_allowout(id_allowout),
        .bj_taken(bj_taken),
        .bj_target(bj_target),
        .ds_fetched(ds_fetched),
        .exc_redirect(exc_redirect),
        .exc_target(exc_target),
        .if_req_valid(if_req_valid),
        .if_req_ready(if_req_ready),
        .if_resp_valid(if_resp_valid),
        .fetch_redirect(fetch_redirect),
        .fetch_target(fetch_target),
        .if_discard(if_discard),
        .if_req_block(if_req_block),
        .ctrl_busy(ctrl_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a redirect owed to fetch, a branch waiting for its delay slot, and one
    // wrong-path flag per outstanding fetch request in issue order.
    logic        m_pending;
    logic        m_await;
    logic [31:0] m_tgt;
    logic        m_q[$];

    always @(negedge clk) begin
        logic fw, any_wrong, e_redir, e_disc, e_block, e_busy, acc, ds_now;
        if (!resetn) begin
            chk("rst_redirect", fetch_redirect, 1'b1);
            chk("rst_target", fetch_target, RESET_PC);
            chk("rst_discard", if_discard, 1'b0);
            chk("rst_block", if_req_block, 1'b0);
            chk("rst_busy", ctrl_busy, 1'b1);
            m_pending = 1'b1;
            m_await   = 1'b0;
            m_tgt     = RESET_PC;
            m_q.delete();
        end else begin
            fw = (m_q.size() > 0) && m_q[0];
            any_wrong = 1'b0;
            foreach (m_q[i]) any_wrong |= m_q[i];
            e_redir = m_pending | exc_redirect;
            e_disc  = if_resp_valid & (exc_redirect | m_pending | fw);
            e_block = (m_q.size() == 3);
            e_busy  = m_pending | m_await | any_wrong;
            chk("redirect", fetch_redirect, e_redir);
            if (e_redir) chk("target", fetch_target, exc_redirect ? exc_target : m_tgt);
            chk("discard", if_discard, e_disc);
            chk("block", if_req_block, e_block);
            chk("busy", ctrl_busy, e_busy);

            acc    = e_redir & if_req_valid & if_req_ready;
            ds_now = if_resp_valid & ~fw;
            if (if_resp_valid && m_q.size() > 0) void'(m_q.pop_front());
            if (exc_redirect) begin
                if (acc) foreach (m_q[i]) m_q[i] = 1'b1;
                else m_tgt = exc_target;
                m_pending = ~acc;
                m_await   = 1'b0;
            end else if (m_pending) begin
                if (acc) begin
                    foreach (m_q[i]) m_q[i] = 1'b1;
                    m_pending = 1'b0;
                end
            end else if (m_await) begin
                if (ds_now) begin
                    m_pending = 1'b1;
                    m_await   = 1'b0;
                end
            end else if (id_valid && id_allowout && bj_taken) begin
                m_tgt = bj_target;
                if (ds_fetched || ds_now) m_pending = 1'b1;
                else m_await = 1'b1;
            end
            if (if_req_valid && if_req_ready) m_q.push_back(1'b0);
        end
    end

    task automatic clr();
        id_valid = 0; id_allowout = 0; bj_taken = 0; bj_target = '0; ds_fetched = 0;
        exc_redirect = 0; exc_target = '0; if_req_valid = 0; if_req_ready = 0; if_resp_valid = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic req();
        clr(); if_req_valid = 1; if_req_ready = 1;
    endtask

    task automatic branch(input logic [31:0] t, input logic ds);
        id_valid = 1; id_allowout = 1; bj_taken = 1; bj_target = t; ds_fetched = ds;
    endtask

    initial begin
        resetn = 0;
        clr();
        look();
        chk("boot_redirect_in_reset", fetch_redirect, 1'b1);
        chk("boot_target_in_reset", fetch_target, 32'hBFC00000);
        tick(); tick();
        resetn = 1;
        look();
        chk("boot_redirect_after", fetch_redirect, 1'b1);
        chk("boot_target_after", fetch_target, 32'hBFC00000);
        tick(); req(); look();
        tick(); clr(); look();
        chk("boot_done_redirect", fetch_redirect, 1'b0);
        chk("boot_done_busy", ctrl_busy, 1'b0);
        tick(); if_resp_valid = 1; look();
        chk("boot_resp_kept", if_discard, 1'b0);

        // taken branch with delay slot already fetched, one request outstanding
        tick(); req();
        tick(); clr(); branch(32'h80001000, 1'b1);
        tick(); clr(); look();
        chk("br_redirect", fetch_redirect, 1'b1);
        chk("br_target", fetch_target, 32'h80001000);
        tick(); req(); look();
        tick(); clr(); if_resp_valid = 1; look();
        chk("br_first_resp_dropped", if_discard, 1'b1);
        tick(); clr(); if_resp_valid = 1; look();
        chk("br_second_resp_kept", if_discard, 1'b0);
        tick(); clr(); look();
        chk("br_idle_busy", ctrl_busy, 1'b0);

        // delay slot returns three cycles after the branch; redirect held four cycles
        tick(); req();
        tick(); req(); branch(32'h80002000, 1'b0);
        tick(); req(); look();
        chk("ds_wait_no_redirect", fetch_redirect, 1'b0);
        tick(); clr(); look();
        chk("ds_wait_busy", ctrl_busy, 1'b1);
        tick(); clr(); if_resp_valid = 1; look();
        chk("ds_resp_kept", if_discard, 1'b0);
        chk("ds_resp_no_redirect", fetch_redirect, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(); clr(); if_req_valid = 1; if_resp_valid = (i < 2); look();
            chk("hold_redirect", fetch_redirect, 1'b1);
            chk("hold_target", fetch_target, 32'h80002000);
            chk("hold_discard", if_discard, (i < 2));
        end
        tick(); req();
        tick(); clr(); look();
        chk("hold_done_busy", ctrl_busy, 1'b0);
        tick(); clr(); if_resp_valid = 1;

        // exception while waiting for the delay slot
        tick(); req();
        tick(); clr(); branch(32'h80003000, 1'b0);
        tick(); clr(); exc_redirect = 1; exc_target = 32'hBFC00380; if_req_valid = 1; look();
        chk("exc_redirect_now", fetch_redirect, 1'b1);
        chk("exc_target_now", fetch_target, 32'hBFC00380);
        tick(); clr(); if_req_valid = 1; look();
        chk("exc_pend_target", fetch_target, 32'hBFC00380);
        tick(); req();
        tick(); clr(); if_resp_valid = 1; look();
        chk("exc_stale_dropped", if_discard, 1'b1);
        tick(); clr(); if_resp_valid = 1; look();
        chk("exc_new_kept", if_discard, 1'b0);
        tick(); clr(); look();
        chk("exc_idle_busy", ctrl_busy, 1'b0);

        // outstanding limit, then asynchronous reset in the middle of PEND
        for (int i = 0; i < 3; i++) begin
            tick(); req();
        end
        tick(); clr(); look();
        chk("limit_block", if_req_block, 1'b1);
        tick(); clr(); if_resp_valid = 1;
        tick(); clr(); look();
        chk("limit_release", if_req_block, 1'b0);
        tick(); req();
        tick(); clr(); branch(32'h80004000, 1'b1);
        tick(); clr(); look();
        chk("pend_before_reset", fetch_redirect, 1'b1);
        chk("pend_block", if_req_block, 1'b1);
        tick(); #2;
        resetn = 0;
        #1;
        chk("async_rst_target", fetch_target, 32'hBFC00000);
        chk("async_rst_block", if_req_block, 1'b0);
        chk("async_rst_busy", ctrl_busy, 1'b1);
        tick(); tick();
        resetn = 1;

        for (int c = 0; c < 4000; c++) begin
            tick();
            if (c >= 2000 && c < 2003) begin
                resetn = 0;
                clr();
            end else begin
                resetn = 1;
                id_valid      = $urandom_range(0, 1);
                id_allowout   = $urandom_range(0, 1);
                bj_taken      = $urandom_range(0, 1);
                bj_target     = $urandom;
                ds_fetched    = $urandom_range(0, 1);
                exc_redirect  = ($urandom_range(0, 15) == 0);
                exc_target    = $urandom;
                if_req_valid  = (m_q.size() < 3) && ($urandom_range(0, 1) == 1);
                if_req_ready  = ($urandom_range(0, 3) != 0);
                if_resp_valid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            end
        end
        tick(); clr();
        look();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
